// File: rtl/fixed_requantize_stream.sv
// Streaming fixed-point requantizer: rounds each signed lane from Q(IN_FRAC) to Q(OUT_FRAC),
// then saturates to the output width, through a 2-stage valid/ready elastic pipeline.
module fixed_requantize_stream #(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic data_out_0_last,
    output logic data_out_0_sat
);

    localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IW    = DATA_IN_0_PRECISION_0;
    localparam int OW    = DATA_OUT_0_PRECISION_0;
    localparam int S     = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    localparam int TOTAL = DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int B     = TOTAL / P;
    localparam int CW    = (B > 1) ? $clog2(B) : 1;

    localparam logic [CW-1:0]    LAST_CNT = CW'(B - 1);
    localparam logic signed [IW:0] RND     = (IW+1)'((S > 0) ? (1 << (S - 1)) : 0);
    localparam logic signed [IW:0] SAT_MAX = (IW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [IW:0] SAT_MIN = (IW+1)'(-(1 << (OW - 1)));

    if (DATA_IN_0_PRECISION_1 < DATA_OUT_0_PRECISION_1) begin : g_bad_frac
        $error("fixed_requantize_stream: output fractional bits exceed input fractional bits");
    end
    if ((TOTAL % P) != 0) begin : g_bad_par
        $error("fixed_requantize_stream: tensor size is not a multiple of lanes per beat");
    end

    logic                 s1_valid;
    logic signed [IW:0]   s1_data [P];
    logic signed [IW:0]   rnd_lane [P];
    logic [P*OW-1:0]      sat_data;
    logic                 sat_any;
    logic [CW-1:0]        cnt;
    logic                 s2_ready;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 out_fire;

    assign out_fire        = data_out_0_valid & data_out_0_ready;
    assign s2_ready        = ~data_out_0_valid | data_out_0_ready;
    assign s1_adv          = s1_valid & s2_ready;
    assign data_in_0_ready = ~s1_valid | s1_adv;
    assign in_fire         = data_in_0_valid & data_in_0_ready;
    assign data_out_0_last = data_out_0_valid & (cnt == LAST_CNT);

    // Sign-extend one bit before adding the rounding constant so the sum cannot overflow.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            rnd_lane[i] = ($signed({data_in_0[i*IW + IW - 1], data_in_0[i*IW +: IW]}) + RND) >>> S;
        end
    end

    always_comb begin
        sat_data = '0;
        sat_any  = 1'b0;
        for (int i = 0; i < P; i++) begin
            if (s1_data[i] > SAT_MAX) begin
                sat_data[i*OW +: OW] = SAT_MAX[OW-1:0];
                sat_any              = 1'b1;
            end else if (s1_data[i] < SAT_MIN) begin
                sat_data[i*OW +: OW] = SAT_MIN[OW-1:0];
                sat_any              = 1'b1;
            end else begin
                sat_data[i*OW +: OW] = s1_data[i][OW-1:0];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid         <= 1'b0;
            // NOTE: data registers are reset too because the output word must read 0 during reset.
            for (int i = 0; i < P; i++) s1_data[i] <= '0;
            data_out_0_valid <= 1'b0;
            data_out_0       <= '0;
            data_out_0_sat   <= 1'b0;
            cnt              <= '0;
        end else begin
            if (data_in_0_ready) s1_valid <= data_in_0_valid;
            if (in_fire) begin
                for (int i = 0; i < P; i++) s1_data[i] <= rnd_lane[i];
            end
            if (s2_ready) data_out_0_valid <= s1_valid;
            if (s1_adv) begin
                data_out_0     <= sat_data;
                data_out_0_sat <= sat_any;
            end
            if (out_fire) cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fixed_requantize_stream.sv
// Self-checking bench for fixed_requantize_stream at default parameters (Q8.8 -> Q4.4, 8 beats/tensor),
// compared against an arithmetic reference model and a FIFO scoreboard.
module tb_fixed_requantize_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        dout_sat;

    fixed_requantize_stream dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .data_in_0_valid  (din_valid),
        .data_in_0_ready  (din_ready),
        .data_out_0       (dout),
        .data_out_0_valid (dout_valid),
        .data_out_0_ready (dout_ready),
        .data_out_0_last  (dout_last),
        .data_out_0_sat   (dout_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       l;
    } exp_t;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         occ      = 0;
    int         push_idx = 0;
    exp_t       q[$];
    logic [7:0] got_d[$];
    logic       got_s[$];
    logic       got_l[$];
    int         acc_cyc[$];
    int         out_cyc[$];
    logic       held = 1'b0;
    logic [7:0] hold_d;
    logic       hold_s;
    logic       hold_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value * 2^-4 rounded half up (floor of x/16 + 1/2), then clamped to int8.
    function automatic exp_t model(input logic [15:0] x, input int idx);
        exp_t e;
        int   r;
        r = int'($signed(x)) + 8;
        r = (r >= 0) ? r / 16 : -((15 - r) / 16);
        e.s = (r > 127) || (r < -128);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        e.d = 8'(r);
        e.l = (idx % 8) == 7;
        return e;
    endfunction

    function automatic void clear_capture();
        got_d.delete(); got_s.delete(); got_l.delete();
        acc_cyc.delete(); out_cyc.delete();
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy, output logic accepted);
        exp_t e;
        if (held) begin
            check("hold_valid", dout_valid, 1'b1);
            check("hold_data", dout, hold_d);
            check("hold_sat", dout_sat, hold_s);
            check("hold_last", dout_last, hold_l);
        end
        din_valid  = iv;
        din        = d;
        dout_ready = ordy;
        #1;
        check("in_ready", din_ready, !(occ == 2 && !ordy));
        accepted = iv && din_ready;
        if (dout_valid && ordy) begin
            if (q.size() == 0) begin
                check("unexpected_beat", dout_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("out_data", dout, e.d);
                check("out_sat", dout_sat, e.s);
                check("out_last", dout_last, e.l);
                occ--;
            end
            got_d.push_back(dout); got_s.push_back(dout_sat); got_l.push_back(dout_last);
            out_cyc.push_back(cyc);
        end
        held = dout_valid && !ordy;
        hold_d = dout; hold_s = dout_sat; hold_l = dout_last;
        if (accepted) begin
            q.push_back(model(d, push_idx));
            push_idx++;
            occ++;
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] d, input logic rand_ready);
        logic acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++)
            step(1'b1, d, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
        check("send_timeout", acc, 1'b1);
    endtask

    task automatic drain(input logic rand_ready);
        logic acc;
        for (int k = 0; k < 500 && q.size() > 0; k++)
            step(1'b0, 16'h0, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
        step(1'b0, 16'h0, 1'b1, acc);
        check("drain_left", q.size(), 0);
        check("drain_valid", dout_valid, 1'b0);
    endtask

    task automatic reset_pulse();
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        rst        = 1'b0;
        #1;
        check("rst_valid", dout_valid, 1'b0);
        check("rst_last", dout_last, 1'b0);
        check("rst_sat", dout_sat, 1'b0);
        check("rst_data", dout, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        occ = 0; push_idx = 0; held = 1'b0;
        clear_capture();
        #1;
        check("ready_after_rst", din_ready, 1'b1);
    endtask

    initial begin
        logic        acc;
        logic [15:0] rnd_words [100];
        int          nlast;

        // Reset state
        reset_pulse();

        // Rounding cases
        send(16'h0128, 1'b0); send(16'h0008, 1'b0); send(16'hFFF8, 1'b0); send(16'hFFF7, 1'b0);
        drain(1'b0);
        check("round_count", got_d.size(), 4);
        check("round_0128", got_d[0], 8'h13); check("round_0128_sat", got_s[0], 1'b0);
        check("round_0008", got_d[1], 8'h01); check("round_0008_sat", got_s[1], 1'b0);
        check("round_FFF8", got_d[2], 8'h00); check("round_FFF8_sat", got_s[2], 1'b0);
        check("round_FFF7", got_d[3], 8'hFF); check("round_FFF7_sat", got_s[3], 1'b0);

        // Saturation cases
        clear_capture();
        send(16'h7FFF, 1'b0); send(16'h8000, 1'b0);
        drain(1'b0);
        check("sat_count", got_d.size(), 2);
        check("sat_pos", got_d[0], 8'h7F); check("sat_pos_flag", got_s[0], 1'b1);
        check("sat_neg", got_d[1], 8'h80); check("sat_neg_flag", got_s[1], 1'b1);

        // Back-to-back streaming of two tensors
        reset_pulse();
        for (int i = 0; i < 16; i++) send(16'($urandom), 1'b0);
        drain(1'b0);
        check("stream_count", got_d.size(), 16);
        check("stream_accept_span", acc_cyc[15] - acc_cyc[0], 15);
        check("stream_latency", out_cyc[0] - acc_cyc[0], 2);
        check("stream_throughput", out_cyc[15] - out_cyc[0], 15);
        nlast = 0;
        for (int i = 0; i < 16; i++) nlast += int'(got_l[i]);
        check("stream_last7", got_l[7], 1'b1);
        check("stream_last15", got_l[15], 1'b1);
        check("stream_last_count", nlast, 2);

        // Random backpressure over 100 beats
        reset_pulse();
        for (int i = 0; i < 100; i++) rnd_words[i] = 16'($urandom);
        for (int i = 0; i < 100; i++) send(rnd_words[i], 1'b1);
        drain(1'b1);
        check("bp_count", got_d.size(), 100);

        // Reset in mid-stream after three outputs
        reset_pulse();
        for (int k = 0; k < 50 && got_d.size() < 3; k++) step(1'b1, 16'($urandom), 1'b1, acc);
        check("mid_outputs", got_d.size(), 3);
        din_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_valid_drop", dout_valid, 1'b0);
        @(negedge clk);
        reset_pulse();
        for (int i = 0; i < 8; i++) send(16'($urandom), 1'b0);
        drain(1'b0);
        check("post_rst_count", got_d.size(), 8);
        nlast = 0;
        for (int i = 0; i < 8; i++) nlast += int'(got_l[i]);
        check("post_rst_last8", got_l[7], 1'b1);
        check("post_rst_last_count", nlast, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_requantize_stream.md
FIXED_REQUANTIZE_STREAM -- requirements
Module: fixed_requantize_stream

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 16: input word width, bits.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 8: input fractional bits.
REQ-003 SHALL have parameter DATA_OUT_0_PRECISION_0, default 8: output word width, bits.
REQ-004 SHALL have parameter DATA_OUT_0_PRECISION_1, default 4: output fractional bits.
REQ-005 SHALL have parameters DATA_IN_0_TENSOR_SIZE_DIM_0 / _DIM_1, defaults 8 / 1: tensor shape.
REQ-006 SHALL have parameters DATA_IN_0_PARALLELISM_DIM_0 / _DIM_1, defaults 1 / 1: lanes per beat.
REQ-007 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port data_in_0, input, P*DATA_IN_0_PRECISION_0, where P = PAR_DIM_0*PAR_DIM_1: signed input lanes, lane 0 in LSBs.
REQ-010 SHALL have port data_in_0_valid, input, 1: upstream beat valid.
REQ-011 SHALL have port data_in_0_ready, output, 1: block accepts a beat.
REQ-012 SHALL have port data_out_0, output, P*DATA_OUT_0_PRECISION_0: requantized signed lanes, consumed directly by the hardtanh stage.
REQ-013 SHALL have port data_out_0_valid, output, 1: output beat valid.
REQ-014 SHALL have port data_out_0_ready, input, 1: downstream accepts.
REQ-015 SHALL have port data_out_0_last, output, 1: high on the final beat of each tensor.
REQ-016 SHALL have port data_out_0_sat, output, 1: high when any lane of the current output beat saturated.

Function
REQ-017 SHALL require DATA_IN_0_PRECISION_1 >= DATA_OUT_0_PRECISION_1; elaboration SHALL fail otherwise. Define S = difference.
REQ-018 SHALL transfer on a port only when valid and ready are both high in the same cycle.
REQ-019 SHALL be a 2-stage elastic pipeline: stage 1 rounds, stage 2 saturates and registers the output.
REQ-020 Stage 1 SHALL compute, per lane, (x + 2^(S-1)) >>> S (round half up, arithmetic shift), at DATA_IN_0_PRECISION_0+1 bits so no intermediate overflow; S=0 passes through unchanged.
REQ-021 Stage 2 SHALL clamp each lane to [-2^(DATA_OUT_0_PRECISION_0-1), 2^(DATA_OUT_0_PRECISION_0-1)-1] and set the sat bit if any lane clamped.
REQ-022 Each stage SHALL load when it is empty or its content leaves in the same cycle; data_in_0_ready = NOT stage-1-full OR stage 1 advancing.
REQ-023 Latency SHALL be 2 cycles, accept to data_out_0_valid, with no stalls; sustained throughput SHALL be 1 beat/cycle.
REQ-024 Under data_out_0_ready low, held data_out_0, _valid, _last and _sat SHALL stay stable; no beat SHALL be dropped or duplicated.
REQ-025 A beat counter SHALL count output transfers modulo B = (DIM_0*DIM_1)/(PAR_DIM_0*PAR_DIM_1); B SHALL be an integer.
REQ-026 data_out_0_last SHALL be high when data_out_0_valid and counter = B-1; the counter SHALL wrap to 0 on that transfer. With B=1, last SHALL be high on every beat.
REQ-027 Simultaneous input and output transfer with both stages full SHALL be accepted in the same cycle, with occupancy unchanged.

Reset
REQ-028 While rst is low: both stage valids = 0, counter = 0, data_out_0_valid = 0, data_out_0_last = 0, data_out_0_sat = 0; data_out_0 SHALL be 0.
REQ-029 Reset asserted mid-tensor SHALL discard in-flight beats; the first beat after release SHALL count as beat 0.
REQ-030 data_in_0_ready SHALL be high in the first cycle after reset release.

Verification (defaults: 16-bit Q8 to 8-bit Q4, S=4, B=8)
REQ-031 Rounding: inputs 0x0128, 0x0008, 0xFFF8, 0xFFF7 -> outputs 0x13, 0x01, 0x00, 0xFF; sat=0 on each.
REQ-032 Saturation: inputs 0x7FFF and 0x8000 -> 0x7F with sat=1, then 0x80 with sat=1.
REQ-033 Streaming: 16 back-to-back beats, ready held high -> first output 2 cycles after the first accept, one beat/cycle, last on beats 7 and 15 only.
REQ-034 Backpressure: random data_out_0_ready at 50% over 100 beats -> output sequence identical to the model, data stable while stalled, data_in_0_ready low only when both stages are full and the output is stalled.
REQ-035 Reset mid-stream after 3 outputs -> valid drops immediately; after release, 8 new beats -> last on the 8th.
